// File: rtl/or1k_ctrl_spr_sequencer.sv
// SPR bus sequencer: arbitrates ctrl-stage l.mfspr/l.mtspr and debug-unit accesses
// onto the shared SPR bus, with a bounded access time and flush-safe draining.
module or1k_ctrl_spr_sequencer #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int SPR_ADDR_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES       = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_op_mfspr_i,
  input  logic                            ctrl_op_mtspr_i,
  input  logic [SPR_ADDR_WIDTH-1:0]       ctrl_spr_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_spr_wdata_i,
  output logic                            ctrl_mfspr_ack_o,
  output logic                            ctrl_mtspr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mfspr_dat_o,
  input  logic                            du_stb_i,
  input  logic                            du_we_i,
  input  logic [SPR_ADDR_WIDTH-1:0]       du_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] du_dat_i,
  output logic                            du_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] du_dat_o,
  output logic                            spr_bus_stb_o,
  output logic                            spr_bus_we_o,
  output logic [SPR_ADDR_WIDTH-1:0]       spr_bus_addr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_bus_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_BUS,
    CPU_HOLD,
    CPU_DRAIN,
    DU_BUS
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                    state, state_next;
  logic [7:0]                count, count_next;
  logic                      stb_next, we_next;
  logic [SPR_ADDR_WIDTH-1:0] addr_next;
  logic [OPTION_OPERAND_WIDTH-1:0] wdat_next, mfspr_dat_next, du_dat_next;
  logic                      mfspr_ack_next, mtspr_ack_next, du_ack_next, timeout_next;
  logic                      cpu_req, du_req, in_bus, bus_done, bus_to;

  // du_ack_o is high in the IDLE cycle right after a DU completion, while the
  // DU may still be holding its strobe; masking it avoids a duplicate access.
  assign cpu_req  = (ctrl_op_mfspr_i | ctrl_op_mtspr_i) & ~pipeline_flush_i;
  assign du_req   = du_stb_i & ~du_ack_o;
  assign in_bus   = (state == CPU_BUS) | (state == CPU_DRAIN) | (state == DU_BUS);
  assign bus_done = in_bus & spr_bus_ack_i;
  assign bus_to   = in_bus & ~spr_bus_ack_i & (count == TIMEOUT_LAST);

  always_comb begin
    state_next     = state;
    count_next     = count;
    stb_next       = spr_bus_stb_o;
    we_next        = spr_bus_we_o;
    addr_next      = spr_bus_addr_o;
    wdat_next      = spr_bus_dat_o;
    mfspr_ack_next = ctrl_mfspr_ack_o;
    mtspr_ack_next = ctrl_mtspr_ack_o;
    mfspr_dat_next = ctrl_mfspr_dat_o;
    du_ack_next    = 1'b0;
    du_dat_next    = du_dat_o;
    timeout_next   = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_next = CPU_BUS;
          count_next = 8'd0;
          stb_next   = 1'b1;
          we_next    = ctrl_op_mtspr_i;
          addr_next  = ctrl_spr_addr_i;
          wdat_next  = ctrl_spr_wdata_i;
        end else if (du_req) begin
          state_next = DU_BUS;
          count_next = 8'd0;
          stb_next   = 1'b1;
          we_next    = du_we_i;
          addr_next  = du_addr_i;
          wdat_next  = du_dat_i;
        end
      end

      CPU_BUS: begin
        count_next = count + 8'd1;
        if (bus_done | bus_to) begin
          state_next     = CPU_HOLD;
          stb_next       = 1'b0;
          mfspr_ack_next = ~spr_bus_we_o;
          mtspr_ack_next = spr_bus_we_o;
          mfspr_dat_next = (bus_done & ~spr_bus_we_o) ? spr_bus_dat_i : '0;
          timeout_next   = bus_to;
        end else if (pipeline_flush_i) begin
          state_next = CPU_DRAIN;
        end
      end

      CPU_HOLD: begin
        if (padv_i | pipeline_flush_i) begin
          state_next     = IDLE;
          mfspr_ack_next = 1'b0;
          mtspr_ack_next = 1'b0;
        end
      end

      // The bus cycle of a flushed instruction still runs to completion.
      CPU_DRAIN: begin
        count_next = count + 8'd1;
        if (bus_done | bus_to) begin
          state_next   = IDLE;
          stb_next     = 1'b0;
          timeout_next = bus_to;
        end
      end

      DU_BUS: begin
        count_next = count + 8'd1;
        if (bus_done | bus_to) begin
          state_next   = IDLE;
          stb_next     = 1'b0;
          du_ack_next  = 1'b1;
          du_dat_next  = (bus_done & ~spr_bus_we_o) ? spr_bus_dat_i : '0;
          timeout_next = bus_to;
        end
      end

      default: begin
        state_next = IDLE;
        stb_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= 8'd0;
      spr_bus_stb_o    <= 1'b0;
      spr_bus_we_o     <= 1'b0;
      spr_bus_addr_o   <= '0;
      spr_bus_dat_o    <= '0;
      ctrl_mfspr_ack_o <= 1'b0;
      ctrl_mtspr_ack_o <= 1'b0;
      ctrl_mfspr_dat_o <= '0;
      du_ack_o         <= 1'b0;
      du_dat_o         <= '0;
      spr_timeout_o    <= 1'b0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      spr_bus_stb_o    <= stb_next;
      spr_bus_we_o     <= we_next;
      spr_bus_addr_o   <= addr_next;
      spr_bus_dat_o    <= wdat_next;
      ctrl_mfspr_ack_o <= mfspr_ack_next;
      ctrl_mtspr_ack_o <= mtspr_ack_next;
      ctrl_mfspr_dat_o <= mfspr_dat_next;
      du_ack_o         <= du_ack_next;
      du_dat_o         <= du_dat_next;
      spr_timeout_o    <= timeout_next;
    end
  end

endmodule

// File: tb/tb_or1k_ctrl_spr_sequencer.sv
// Directed bench for or1k_ctrl_spr_sequencer: one task per scenario with
// hand-computed cycle-by-cycle expectations.
module tb_or1k_ctrl_spr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv_i, pipeline_flush_i, ctrl_op_mfspr_i, ctrl_op_mtspr_i;
  logic [15:0] ctrl_spr_addr_i;
  logic [31:0] ctrl_spr_wdata_i;
  logic        ctrl_mfspr_ack_o, ctrl_mtspr_ack_o;
  logic [31:0] ctrl_mfspr_dat_o;
  logic        du_stb_i, du_we_i;
  logic [15:0] du_addr_i;
  logic [31:0] du_dat_i;
  logic        du_ack_o;
  logic [31:0] du_dat_o;
  logic        spr_bus_stb_o, spr_bus_we_o;
  logic [15:0] spr_bus_addr_o;
  logic [31:0] spr_bus_dat_o;
  logic        spr_bus_ack_i;
  logic [31:0] spr_bus_dat_i;
  logic        spr_timeout_o;

  int total = 0;
  int bad   = 0;

  or1k_ctrl_spr_sequencer #(
    .OPTION_OPERAND_WIDTH(32),
    .SPR_ADDR_WIDTH(16),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst), .padv_i(padv_i), .pipeline_flush_i(pipeline_flush_i),
    .ctrl_op_mfspr_i(ctrl_op_mfspr_i), .ctrl_op_mtspr_i(ctrl_op_mtspr_i),
    .ctrl_spr_addr_i(ctrl_spr_addr_i), .ctrl_spr_wdata_i(ctrl_spr_wdata_i),
    .ctrl_mfspr_ack_o(ctrl_mfspr_ack_o), .ctrl_mtspr_ack_o(ctrl_mtspr_ack_o),
    .ctrl_mfspr_dat_o(ctrl_mfspr_dat_o),
    .du_stb_i(du_stb_i), .du_we_i(du_we_i), .du_addr_i(du_addr_i), .du_dat_i(du_dat_i),
    .du_ack_o(du_ack_o), .du_dat_o(du_dat_o),
    .spr_bus_stb_o(spr_bus_stb_o), .spr_bus_we_o(spr_bus_we_o),
    .spr_bus_addr_o(spr_bus_addr_o), .spr_bus_dat_o(spr_bus_dat_o),
    .spr_bus_ack_i(spr_bus_ack_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_timeout_o(spr_timeout_o)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; padv_i = 0; pipeline_flush_i = 0; ctrl_op_mfspr_i = 0; ctrl_op_mtspr_i = 0;
    ctrl_spr_addr_i = 0; ctrl_spr_wdata_i = 0; du_stb_i = 0; du_we_i = 0; du_addr_i = 0;
    du_dat_i = 0; spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    tick(); tick(); tick();
    total++; if ({spr_bus_stb_o, spr_bus_we_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, du_ack_o, spr_timeout_o} !== 6'b0) begin bad++; $display("[TB] FAIL reset_flags: got %b want 000000", {spr_bus_stb_o, spr_bus_we_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, du_ack_o, spr_timeout_o}); end
    total++; if ({spr_bus_addr_o, spr_bus_dat_o, ctrl_mfspr_dat_o, du_dat_o} !== 112'd0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", {spr_bus_addr_o, spr_bus_dat_o, ctrl_mfspr_dat_o, du_dat_o}); end
    rst = 1'b0;
    tick();
    total++; if (spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_stb: got %b want 0", spr_bus_stb_o); end
  endtask

  task automatic test_mfspr();
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0011;
    tick();
    total++; if ({spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o} !== {2'b10, 16'h0011}) begin bad++; $display("[TB] FAIL mf_start: got stb=%b we=%b addr=%h want 1 0 0011", spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o); end
    tick(); tick();
    total++; if ({spr_bus_stb_o, ctrl_mfspr_ack_o} !== 2'b10) begin bad++; $display("[TB] FAIL mf_wait: got stb=%b ack=%b want 1 0", spr_bus_stb_o, ctrl_mfspr_ack_o); end
    tick();
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'hDEADBEEF;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({spr_bus_stb_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, spr_timeout_o} !== 4'b0100) begin bad++; $display("[TB] FAIL mf_ack: got stb=%b mf=%b mt=%b to=%b want 0 1 0 0", spr_bus_stb_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, spr_timeout_o); end
    total++; if (ctrl_mfspr_dat_o !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL mf_dat: got %h want deadbeef", ctrl_mfspr_dat_o); end
    tick(); tick();
    total++; if ({ctrl_mfspr_ack_o, ctrl_mfspr_dat_o, spr_bus_stb_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin bad++; $display("[TB] FAIL mf_hold: got ack=%b dat=%h stb=%b want 1 deadbeef 0", ctrl_mfspr_ack_o, ctrl_mfspr_dat_o, spr_bus_stb_o); end
    padv_i = 1;
    tick();
    padv_i = 0; ctrl_op_mfspr_i = 0;
    total++; if (ctrl_mfspr_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL mf_release: got %b want 0", ctrl_mfspr_ack_o); end
    tick();
  endtask

  task automatic test_priority();
    ctrl_op_mtspr_i = 1; ctrl_spr_addr_i = 16'h2000; ctrl_spr_wdata_i = 32'h5;
    du_stb_i = 1; du_we_i = 0; du_addr_i = 16'h0042; du_dat_i = 32'h0;
    tick();
    total++; if ({spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o} !== {2'b11, 16'h2000, 32'h5}) begin bad++; $display("[TB] FAIL pri_cpu_first: got stb=%b we=%b addr=%h dat=%h want 1 1 2000 00000005", spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o); end
    spr_bus_ack_i = 1;
    tick();
    spr_bus_ack_i = 0;
    total++; if ({ctrl_mtspr_ack_o, ctrl_mfspr_ack_o, spr_bus_stb_o, du_ack_o} !== 4'b1000) begin bad++; $display("[TB] FAIL pri_mt_ack: got mt=%b mf=%b stb=%b du=%b want 1 0 0 0", ctrl_mtspr_ack_o, ctrl_mfspr_ack_o, spr_bus_stb_o, du_ack_o); end
    tick();
    total++; if ({ctrl_mtspr_ack_o, spr_bus_stb_o} !== 2'b10) begin bad++; $display("[TB] FAIL pri_du_waits: got mt=%b stb=%b want 1 0", ctrl_mtspr_ack_o, spr_bus_stb_o); end
    padv_i = 1; ctrl_op_mtspr_i = 0;
    tick();
    padv_i = 0;
    total++; if ({ctrl_mtspr_ack_o, spr_bus_stb_o} !== 2'b00) begin bad++; $display("[TB] FAIL pri_hold_exit: got mt=%b stb=%b want 0 0", ctrl_mtspr_ack_o, spr_bus_stb_o); end
    tick();
    total++; if ({spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o} !== {2'b10, 16'h0042}) begin bad++; $display("[TB] FAIL pri_du_stb: got stb=%b we=%b addr=%h want 1 0 0042", spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o); end
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'h12345678;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({du_ack_o, du_dat_o, spr_bus_stb_o} !== {1'b1, 32'h12345678, 1'b0}) begin bad++; $display("[TB] FAIL pri_du_ack: got ack=%b dat=%h stb=%b want 1 12345678 0", du_ack_o, du_dat_o, spr_bus_stb_o); end
    tick();
    du_stb_i = 0;
    total++; if ({du_ack_o, spr_bus_stb_o} !== 2'b00) begin bad++; $display("[TB] FAIL pri_du_pulse: got ack=%b stb=%b want 0 0", du_ack_o, spr_bus_stb_o); end
    tick();
    total++; if ({du_ack_o, spr_bus_stb_o} !== 2'b00) begin bad++; $display("[TB] FAIL pri_du_once: got ack=%b stb=%b want 0 0", du_ack_o, spr_bus_stb_o); end
  endtask

  task automatic test_timeout();
    int n;
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0033; spr_bus_dat_i = 32'hFFFFFFFF;
    tick();
    n = 0;
    while (spr_bus_stb_o === 1'b1 && n < 40) begin
      total++; if (spr_timeout_o !== 1'b0) begin bad++; $display("[TB] FAIL to_early: got %b want 0 at stb cycle %0d", spr_timeout_o, n); end
      n++;
      tick();
    end
    total++; if (n !== 15) begin bad++; $display("[TB] FAIL to_stb_len: got %0d want 15", n); end
    total++; if ({spr_timeout_o, ctrl_mfspr_ack_o, ctrl_mfspr_dat_o} !== {2'b11, 32'h0}) begin bad++; $display("[TB] FAIL to_complete: got to=%b ack=%b dat=%h want 1 1 00000000", spr_timeout_o, ctrl_mfspr_ack_o, ctrl_mfspr_dat_o); end
    spr_bus_dat_i = 0;
    tick();
    total++; if ({spr_timeout_o, ctrl_mfspr_ack_o} !== 2'b01) begin bad++; $display("[TB] FAIL to_pulse: got to=%b ack=%b want 0 1", spr_timeout_o, ctrl_mfspr_ack_o); end
    padv_i = 1;
    tick();
    padv_i = 0; ctrl_op_mfspr_i = 0;
    tick();
  endtask

  task automatic test_ack_at_timeout();
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0066;
    tick();
    for (int i = 0; i < 14; i++) tick();
    total++; if (spr_bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL edge_stb15: got %b want 1", spr_bus_stb_o); end
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'h00000077;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({spr_timeout_o, ctrl_mfspr_ack_o, ctrl_mfspr_dat_o} !== {2'b01, 32'h77}) begin bad++; $display("[TB] FAIL edge_ack_wins: got to=%b ack=%b dat=%h want 0 1 00000077", spr_timeout_o, ctrl_mfspr_ack_o, ctrl_mfspr_dat_o); end
    padv_i = 1; pipeline_flush_i = 1;
    tick();
    padv_i = 0; pipeline_flush_i = 0; ctrl_op_mfspr_i = 0;
    total++; if ({ctrl_mfspr_ack_o, spr_bus_stb_o} !== 2'b00) begin bad++; $display("[TB] FAIL edge_padv_flush: got ack=%b stb=%b want 0 0", ctrl_mfspr_ack_o, spr_bus_stb_o); end
    tick();
  endtask

  task automatic test_flush();
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0044;
    tick();
    tick();
    pipeline_flush_i = 1;
    tick();
    pipeline_flush_i = 0; ctrl_op_mfspr_i = 0;
    total++; if (spr_bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL fl_drain_stb: got %b want 1", spr_bus_stb_o); end
    tick();
    tick();
    total++; if ({spr_bus_stb_o, ctrl_mfspr_ack_o} !== 2'b10) begin bad++; $display("[TB] FAIL fl_stb_c5: got stb=%b ack=%b want 1 0", spr_bus_stb_o, ctrl_mfspr_ack_o); end
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'h0000CAFE;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({spr_bus_stb_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, spr_timeout_o} !== 4'b0000) begin bad++; $display("[TB] FAIL fl_no_ack: got stb=%b mf=%b mt=%b to=%b want 0 0 0 0", spr_bus_stb_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, spr_timeout_o); end
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0055;
    tick();
    total++; if ({spr_bus_stb_o, spr_bus_addr_o} !== {1'b1, 16'h0055}) begin bad++; $display("[TB] FAIL fl_next_stb: got stb=%b addr=%h want 1 0055", spr_bus_stb_o, spr_bus_addr_o); end
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'h0BADF00D;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({ctrl_mfspr_ack_o, ctrl_mfspr_dat_o} !== {1'b1, 32'h0BADF00D}) begin bad++; $display("[TB] FAIL fl_next_ack: got ack=%b dat=%h want 1 0badf00d", ctrl_mfspr_ack_o, ctrl_mfspr_dat_o); end
    padv_i = 1;
    tick();
    padv_i = 0; ctrl_op_mfspr_i = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0101;
    tick();
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'hAAAA0001;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({ctrl_mfspr_ack_o, ctrl_mfspr_dat_o} !== {1'b1, 32'hAAAA0001}) begin bad++; $display("[TB] FAIL b2b_first: got ack=%b dat=%h want 1 aaaa0001", ctrl_mfspr_ack_o, ctrl_mfspr_dat_o); end
    padv_i = 1; ctrl_spr_addr_i = 16'h0102;
    tick();
    padv_i = 0;
    total++; if ({ctrl_mfspr_ack_o, spr_bus_stb_o} !== 2'b00) begin bad++; $display("[TB] FAIL b2b_gap: got ack=%b stb=%b want 0 0", ctrl_mfspr_ack_o, spr_bus_stb_o); end
    tick();
    total++; if ({spr_bus_stb_o, spr_bus_addr_o} !== {1'b1, 16'h0102}) begin bad++; $display("[TB] FAIL b2b_second_stb: got stb=%b addr=%h want 1 0102", spr_bus_stb_o, spr_bus_addr_o); end
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'hBBBB0002;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({ctrl_mfspr_ack_o, ctrl_mfspr_dat_o} !== {1'b1, 32'hBBBB0002}) begin bad++; $display("[TB] FAIL b2b_second: got ack=%b dat=%h want 1 bbbb0002", ctrl_mfspr_ack_o, ctrl_mfspr_dat_o); end
    padv_i = 1; ctrl_op_mfspr_i = 0;
    tick();
    padv_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0077;
    tick();
    total++; if (spr_bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_stb: got %b want 1", spr_bus_stb_o); end
    rst = 1;
    tick();
    rst = 0; ctrl_op_mfspr_i = 0;
    total++; if ({spr_bus_stb_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, du_ack_o} !== 4'b0000) begin bad++; $display("[TB] FAIL rst_mid: got stb=%b mf=%b mt=%b du=%b want 0 0 0 0", spr_bus_stb_o, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, du_ack_o); end
    tick();
    ctrl_op_mfspr_i = 1; ctrl_spr_addr_i = 16'h0078;
    tick();
    total++; if ({spr_bus_stb_o, spr_bus_addr_o} !== {1'b1, 16'h0078}) begin bad++; $display("[TB] FAIL rst_idle_restart: got stb=%b addr=%h want 1 0078", spr_bus_stb_o, spr_bus_addr_o); end
    spr_bus_ack_i = 1; spr_bus_dat_i = 32'h00000078;
    tick();
    spr_bus_ack_i = 0; spr_bus_dat_i = 0;
    total++; if ({ctrl_mfspr_ack_o, ctrl_mfspr_dat_o} !== {1'b1, 32'h78}) begin bad++; $display("[TB] FAIL rst_restart_ack: got ack=%b dat=%h want 1 00000078", ctrl_mfspr_ack_o, ctrl_mfspr_dat_o); end
    padv_i = 1; ctrl_op_mfspr_i = 0;
    tick();
    padv_i = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_mfspr();
    test_priority();
    test_timeout();
    test_ack_at_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or1k_ctrl_spr_sequencer.md
Name: or1k_ctrl_spr_sequencer

Overview:
- Sequences the shared SPR bus between ctrl-stage l.mfspr/l.mtspr and the debug unit (DU).
- Generates the ctrl-stage mfspr/mtspr acknowledges that release the ctrl stall. These acknowledges feed the execute-to-ctrl pipeline register block.
- Bounds every bus access with a timeout.
- Handles pipeline flush while a bus cycle is in flight.

Parameters:
- OPTION_OPERAND_WIDTH, 32, SPR data width.
- SPR_ADDR_WIDTH, 16, SPR address width.
- TIMEOUT_CYCLES, 15, maximum stb cycles before forced completion (1..255). Counter width is 8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- padv_i  in  1  execute-to-ctrl advance; a new instruction is loaded into ctrl next edge
- pipeline_flush_i  in  1  flush of ctrl stage
- ctrl_op_mfspr_i  in  1  ctrl stage holds l.mfspr
- ctrl_op_mtspr_i  in  1  ctrl stage holds l.mtspr
- ctrl_spr_addr_i  in  SPR_ADDR_WIDTH  ctrl SPR address
- ctrl_spr_wdata_i  in  OPTION_OPERAND_WIDTH  mtspr data
- ctrl_mfspr_ack_o  out  1  mfspr done
- ctrl_mtspr_ack_o  out  1  mtspr done
- ctrl_mfspr_dat_o  out  OPTION_OPERAND_WIDTH  mfspr read data
- du_stb_i  in  1  DU request, held until du_ack_o
- du_we_i  in  1  DU write
- du_addr_i  in  SPR_ADDR_WIDTH  DU address
- du_dat_i  in  OPTION_OPERAND_WIDTH  DU write data
- du_ack_o  out  1  DU one-cycle completion pulse
- du_dat_o  out  OPTION_OPERAND_WIDTH  DU read data
- spr_bus_stb_o  out  1  bus strobe
- spr_bus_we_o  out  1  bus write
- spr_bus_addr_o  out  SPR_ADDR_WIDTH  bus address
- spr_bus_dat_o  out  OPTION_OPERAND_WIDTH  bus write data
- spr_bus_ack_i  in  1  bus ack
- spr_bus_dat_i  in  OPTION_OPERAND_WIDTH  bus read data
- spr_timeout_o  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset mid-access returns to IDLE immediately, and stb drops the next cycle.
- All outputs are registered.
- States: IDLE, CPU_BUS, CPU_HOLD, CPU_DRAIN, DU_BUS.
- IDLE:
  - cpu_req = (mfspr|mtspr) & !pipeline_flush_i.
  - If cpu_req, go to CPU_BUS and latch addr/we(=mtspr)/wdata.
  - Else if du_stb_i, go to DU_BUS and latch DU fields.
  - CPU has fixed priority.
  - stb is asserted from the cycle after the transition.
- CPU_BUS:
  - stb=1; counter increments each stb cycle.
  - On spr_bus_ack_i: drop stb next edge; capture read data (0 for writes); assert the matching ctrl ack next edge; go to CPU_HOLD.
  - When counter reaches TIMEOUT_CYCLES-1 without ack: same as ack, but read data = 0 and spr_timeout_o pulses.
  - If pipeline_flush_i and not completing this cycle, go to CPU_DRAIN.
- CPU_HOLD:
  - The ctrl ack and data stay held, because ctrl may stay occupied while execute stalls.
  - Return to IDLE, acks deasserted, on padv_i or pipeline_flush_i.
  - A new op in ctrl (back-to-back mfspr) therefore starts a fresh access from IDLE.
- CPU_DRAIN:
  - Bus cycles are never aborted; stb stays 1 until ack or timeout.
  - Then go to IDLE with no ctrl ack. spr_timeout_o still pulses on timeout.
- DU_BUS:
  - Same as CPU_BUS, but on completion du_ack_o pulses for one cycle with du_dat_o, then go to IDLE.
  - Flush does not affect DU_BUS. A CPU request arriving meanwhile waits.
- Latency: op in IDLE at cycle N, then stb at N+1. If the bus acks at N+1, the ctrl ack is at N+2. Minimum is 2 cycles.
- Counter clears on every entry to a bus state.
- Simultaneous ack and timeout: treated as ack, no timeout pulse.
- Simultaneous padv_i and flush in CPU_HOLD: go to IDLE.
- Exactly one bus requester at a time; stb is never asserted in IDLE or CPU_HOLD.

Test Plan:
- mfspr addr 0x0011, bus acks 3 cycles after stb with data 0xDEADBEEF → ctrl_mfspr_ack_o rises 1 cycle after ack with dat 0xDEADBEEF, held until padv_i, then 0.
- mtspr addr 0x2000 data 0x5, and du_stb_i in the same cycle → CPU served first, with spr_bus_we_o=1. DU stb starts the cycle after CPU_HOLD exits; du_ack_o pulses once.
- mfspr with no bus ack, TIMEOUT_CYCLES=15 → stb high exactly 15 cycles; spr_timeout_o pulses; ack with dat 0.
- Flush 2 cycles into a CPU access, ack at cycle 5 → stb held through the ack, no ctrl ack, back to IDLE; next mfspr proceeds normally.
- Back-to-back mfspr with padv_i between them → two separate stb cycles and two ack phases.
- rst asserted during CPU_BUS → stb and acks 0 the next cycle; state IDLE.
